// File: rtl/proj_sort_feeder_if.sv
// proj_sort_feeder_if
//   Groups the feeder's hasher-side handshake, the sorter input bus and the
//   result handshake with the downstream extender.
//   slave  : the feeder (drives hash_ready and the sort_* / end_sorting bus)
//   master : the surrounding hasher / sorter / extender side
//   Signals:
//     hash_valid, hash_signature : hasher beat
//     hash_ready                 : feeder can accept a beat
//     sort_signature, sort_index : sorter in_signature / in_index
//     sort_clr                   : active-high sorter clear
//     end_sorting                : sorter result valid while high
//     res_ready                  : downstream has consumed the result
interface proj_sort_feeder_if #(
    parameter int INDICE_LEN    = 6,
    parameter int SIGNATURE_LEN = 32
);
    logic                     hash_valid;
    logic                     hash_ready;
    logic [SIGNATURE_LEN-1:0] hash_signature;
    logic [SIGNATURE_LEN-1:0] sort_signature;
    logic [INDICE_LEN-1:0]    sort_index;
    logic                     sort_clr;
    logic                     end_sorting;
    logic                     res_ready;

    modport slave (
        input  hash_valid, hash_signature, res_ready,
        output hash_ready, sort_signature, sort_index, sort_clr, end_sorting
    );

    modport master (
        output hash_valid, hash_signature, res_ready,
        input  hash_ready, sort_signature, sort_index, sort_clr, end_sorting
    );
endinterface

// File: rtl/proj_sort_feeder.sv
// proj_sort_feeder
//   Front-end sequencer for the MinHash sorter. Accepts hashed signatures,
//   tags each with a running index, feeds one pair per cycle to the sorter's
//   free-running input (all-ones bubbles between beats), clears the sorter
//   between sets and holds end_sorting until the result is consumed.
//   Ports:
//     clk, rst : clock, asynchronous active-high reset
//     start    : begin a new set (sampled in IDLE only)
//     abort    : restart the current set (only with PROJ_SORT_FEEDER_ABORT_EN)
//     busy     : high in every state except IDLE
//     done     : one-cycle pulse when a set completes
//     bus      : proj_sort_feeder_if.slave (hasher, sorter and result signals)
//   Build option: define PROJ_SORT_FEEDER_ABORT_EN to add the abort input.
//
//   state | meaning
//   IDLE  | waiting for start, bubble output
//   CLEAR | one-cycle sorter clear, beat counter reset
//   FEED  | accepting beats from the hasher
//   FLUSH | last beat on sorter inputs, sorter captures it this cycle
//   HOLD  | end_sorting high until res_ready
module proj_sort_feeder #(
    parameter int INDICE_LEN     = 6,
    parameter int SIGNATURE_LEN  = 32,
    parameter int NUM_SIGNATURES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
`ifdef PROJ_SORT_FEEDER_ABORT_EN
    input  logic abort,
`endif
    output logic busy,
    output logic done,
    proj_sort_feeder_if.slave bus
);
    localparam int CNT_W = INDICE_LEN + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SIGNATURES - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, FLUSH, HOLD} state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic             abort_req;
    logic             accept;

`ifdef PROJ_SORT_FEEDER_ABORT_EN
    assign abort_req = abort && (state != IDLE);
`else
    assign abort_req = 1'b0;
`endif

    // An abort wins over a simultaneous handshake; that beat is dropped.
    assign accept         = (state == FEED) && bus.hash_valid && !abort_req;
    assign bus.hash_ready = (state == FEED);
    assign busy           = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = CLEAR;
            CLEAR:   next_state = FEED;
            FEED:    if (accept && (cnt == LAST_CNT)) next_state = FLUSH;
            FLUSH:   next_state = HOLD;
            HOLD:    if (bus.res_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (abort_req) next_state = CLEAR;
    end

    // Registered outputs. sort_clr comes up in reset and stays high until the
    // first edge after reset release, keeping the sorter cleared meanwhile.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt                <= '0;
            bus.sort_signature <= '1;
            bus.sort_index     <= '0;
            bus.sort_clr       <= 1'b1;
            bus.end_sorting    <= 1'b0;
            done               <= 1'b0;
        end else begin
            bus.sort_clr    <= (next_state == CLEAR);
            bus.end_sorting <= (next_state == HOLD);
            done            <= (state == HOLD) && bus.res_ready && !abort_req;
            if (accept) begin
                bus.sort_signature <= bus.hash_signature;
                bus.sort_index     <= cnt[INDICE_LEN-1:0];
                cnt                <= cnt + CNT_W'(1);
            end else begin
                bus.sort_signature <= '1;
                bus.sort_index     <= '0;
                if (state == CLEAR) cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_proj_sort_feeder.sv
module tb_proj_sort_feeder;
    localparam int IL  = 6;
    localparam int SL  = 32;
    localparam int NUM = 4;

    logic clk;
    logic rst;
    logic start;
    logic busy;
    logic done;
`ifdef PROJ_SORT_FEEDER_ABORT_EN
    logic abort;
`endif

    proj_sort_feeder_if #(.INDICE_LEN(IL), .SIGNATURE_LEN(SL)) bus ();

    proj_sort_feeder #(.INDICE_LEN(IL), .SIGNATURE_LEN(SL), .NUM_SIGNATURES(NUM)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
`ifdef PROJ_SORT_FEEDER_ABORT_EN
        .abort(abort),
`endif
        .busy (busy),
        .done (done),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_mis = 0;
    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(string nm, longint act, longint exp);
        n_vec++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model (timestamp based) ----------------
    int          m_edge   = 0;
    bit          m_active = 1'b0;
    int          m_ts     = 0;
    int          m_tl     = 0;
    int          m_beats  = 0;
    logic [SL-1:0] e_sig  = '1;
    logic [IL-1:0] e_idx  = '0;
    bit          e_clr    = 1'b1;
    bit          e_end    = 1'b0;
    bit          e_done   = 1'b0;

    function automatic bit m_ready();
        return m_active && (m_edge >= m_ts + 1) && (m_beats < NUM);
    endfunction

    always @(posedge clk or posedge rst) begin : model
        bit rdy;
        bit was_end;
        bit abort_now;
        if (rst) begin
            m_active = 1'b0;
            m_beats  = 0;
            e_sig    = '1;
            e_idx    = '0;
            e_clr    = 1'b1;
            e_end    = 1'b0;
            e_done   = 1'b0;
        end else begin
            rdy       = m_ready();
            was_end   = e_end;
            abort_now = 1'b0;
`ifdef PROJ_SORT_FEEDER_ABORT_EN
            abort_now = abort && m_active;
`endif
            m_edge++;
            e_sig  = '1;
            e_idx  = '0;
            e_clr  = 1'b0;
            e_done = 1'b0;
            if (abort_now) begin
                m_ts    = m_edge;
                m_beats = 0;
                e_clr   = 1'b1;
                e_end   = 1'b0;
            end else if (!m_active) begin
                e_end = 1'b0;
                if (start) begin
                    m_active = 1'b1;
                    m_ts     = m_edge;
                    m_beats  = 0;
                    e_clr    = 1'b1;
                end
            end else if (was_end) begin
                if (bus.res_ready) begin
                    e_done   = 1'b1;
                    e_end    = 1'b0;
                    m_active = 1'b0;
                end
            end else begin
                if (rdy && bus.hash_valid) begin
                    e_sig = bus.hash_signature;
                    e_idx = IL'(m_beats);
                    m_beats++;
                    if (m_beats == NUM) m_tl = m_edge;
                end
                e_end = (m_beats == NUM) && (m_edge == m_tl + 1);
            end
        end
    end

    // ---------------- per-cycle compare + recorder ----------------
    logic [SL-1:0] rec_sig[$];
    int            rec_idx[$];
    int            end_rise, done_edge, end_cycles, clr_cycles, done_cnt;
    bit            prev_end = 1'b0;

    task automatic clear_rec();
        rec_sig.delete();
        rec_idx.delete();
        end_rise   = -1;
        done_edge  = -1;
        end_cycles = 0;
        clr_cycles = 0;
        done_cnt   = 0;
    endtask

    always @(negedge clk) begin
        n_vec++;
        if ({bus.sort_signature, bus.sort_index, bus.sort_clr, bus.end_sorting,
             bus.hash_ready, busy, done} !==
            {e_sig, e_idx, e_clr, e_end, m_ready(), m_active, e_done}) begin
            n_mis++;
            $display("FAIL cycle %0d: got sig=%h idx=%0d clr=%b end=%b rdy=%b busy=%b done=%b, expected sig=%h idx=%0d clr=%b end=%b rdy=%b busy=%b done=%b",
                     edge_cnt, bus.sort_signature, bus.sort_index, bus.sort_clr, bus.end_sorting,
                     bus.hash_ready, busy, done, e_sig, e_idx, e_clr, e_end, m_ready(), m_active, e_done);
        end
        if (!rst) begin
            if (bus.sort_signature != '1) begin
                rec_sig.push_back(bus.sort_signature);
                rec_idx.push_back(int'(bus.sort_index));
            end
            if (bus.end_sorting && !prev_end) end_rise = edge_cnt;
            if (bus.end_sorting) end_cycles++;
            if (bus.sort_clr) clr_cycles++;
            if (done) begin
                done_cnt++;
                done_edge = edge_cnt;
            end
        end
        prev_end = bus.end_sorting;
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_start(output int ts);
        start = 1'b1;
        @(posedge clk); #1;
        ts    = edge_cnt;
        start = 1'b0;
    endtask

    task automatic send(input logic [SL-1:0] sig, input bit gap);
        bit r;
        bit ok;
        ok = 1'b0;
        bus.hash_valid     = 1'b1;
        bus.hash_signature = sig;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            r = bus.hash_ready;
            @(posedge clk); #1;
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("send_timeout", 0, 1);
        if (gap) begin
            bus.hash_valid = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("done_timeout", 0, 1);
    endtask

    task automatic wait_end();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.end_sorting) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("end_timeout", 0, 1);
    endtask

    task automatic check_rec_idx(string nm);
        chk({nm, "_count"}, rec_idx.size(), NUM);
        for (int k = 0; k < rec_idx.size(); k++) chk({nm, "_idx"}, rec_idx[k], k);
    endtask

    // Order the sorter would produce: ascending signature, earlier entry wins ties.
    task automatic check_sorted(string nm, int e0, int e1, int e2, int e3);
        int ord[4];
        bit used[4];
        int best;
        int expv[4];
        expv = '{e0, e1, e2, e3};
        if (rec_sig.size() != 4) begin
            chk({nm, "_size"}, rec_sig.size(), 4);
        end else begin
            used = '{0, 0, 0, 0};
            for (int k = 0; k < 4; k++) begin
                best = -1;
                for (int j = 0; j < 4; j++)
                    if (!used[j] && (best < 0 || rec_sig[j] < rec_sig[best])) best = j;
                used[best] = 1'b1;
                ord[k] = rec_idx[best];
            end
            for (int k = 0; k < 4; k++) chk({nm, "_order"}, ord[k], expv[k]);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int ts;
        int ts2;
        logic [SL-1:0] s1[4];
        logic [SL-1:0] s4[4];

        rst = 1'b1;
        start = 1'b0;
        bus.hash_valid = 1'b0;
        bus.hash_signature = '0;
        bus.res_ready = 1'b0;
`ifdef PROJ_SORT_FEEDER_ABORT_EN
        abort = 1'b0;
`endif
        clear_rec();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Basic set
        s1 = '{32'd40, 32'd10, 32'd30, 32'd20};
        bus.res_ready = 1'b1;
        clear_rec();
        do_start(ts);
        for (int k = 0; k < 4; k++) send(s1[k], 1'b0);
        bus.hash_valid = 1'b0;
        wait_done();
        @(posedge clk); #1;
        check_rec_idx("basic");
        for (int k = 0; k < rec_sig.size() && k < 4; k++) chk("basic_sig", rec_sig[k], s1[k]);
        check_sorted("basic", 1, 3, 2, 0);
        chk("basic_end_at", end_rise - ts, 6);
        chk("basic_done_at", done_edge - ts, 7);
        chk("basic_clr_cycles", clr_cycles, 1);
        chk("basic_done_cnt", done_cnt, 1);

        // Bubbles between beats
        clear_rec();
        do_start(ts);
        for (int k = 0; k < 4; k++) send(s1[k], 1'b1);
        wait_done();
        @(posedge clk); #1;
        check_rec_idx("bubble");
        check_sorted("bubble", 1, 3, 2, 0);
        chk("bubble_done_at", done_edge - ts, 10);

        // Backpressure on result; start during HOLD must be ignored
        bus.res_ready = 1'b0;
        clear_rec();
        do_start(ts);
        for (int k = 0; k < 4; k++) send(SL'(k + 5), 1'b0);
        bus.hash_valid = 1'b0;
        wait_end();
        start = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        bus.res_ready = 1'b1;
        start = 1'b0;
        wait_done();
        @(posedge clk); #1;
        chk("bp_end_cycles", end_cycles, 11);
        chk("bp_done_after_end", done_edge - end_rise, 11);
        chk("bp_done_cnt", done_cnt, 1);
        repeat (3) @(posedge clk);
        #1 chk("bp_no_restart", busy, 0);

        // Back-to-back sets
        clear_rec();
        do_start(ts);
        for (int k = 0; k < 4; k++) send(SL'(100 * (k + 1)), 1'b0);
        bus.hash_valid = 1'b0;
        wait_done();
        start = 1'b1;
        @(posedge clk); #1;
        ts2 = edge_cnt;
        start = 1'b0;
        clear_rec();
        s4 = '{32'd4, 32'd3, 32'd2, 32'd1};
        for (int k = 0; k < 4; k++) send(s4[k], 1'b0);
        bus.hash_valid = 1'b0;
        wait_done();
        @(posedge clk); #1;
        chk("b2b_clr_cycles", clr_cycles, 1);
        check_rec_idx("b2b");
        for (int k = 0; k < rec_sig.size() && k < 4; k++) chk("b2b_sig", rec_sig[k], s4[k]);
        check_sorted("b2b", 3, 2, 1, 0);
        chk("b2b_done_at", done_edge - ts2, 7);

        // Mid-set reset
        clear_rec();
        do_start(ts);
        send(32'd11, 1'b0);
        send(32'd22, 1'b0);
        bus.hash_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_clr", bus.sort_clr, 1);
        chk("rst_sig", bus.sort_signature, 64'hFFFF_FFFF);
        chk("rst_idx", bus.sort_index, 0);
        chk("rst_end", bus.end_sorting, 0);
        chk("rst_ready", bus.hash_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1 chk("rst_no_done", done_cnt, 0);
        clear_rec();
        do_start(ts);
        for (int k = 0; k < 4; k++) send(SL'(9 - k), 1'b0);
        bus.hash_valid = 1'b0;
        wait_done();
        @(posedge clk); #1;
        check_sorted("post_rst", 3, 2, 1, 0);
        chk("post_rst_done_at", done_edge - ts, 7);

`ifdef PROJ_SORT_FEEDER_ABORT_EN
        // Abort on the 3rd beat
        clear_rec();
        do_start(ts);
        send(32'd50, 1'b0);
        send(32'd60, 1'b0);
        bus.hash_valid = 1'b1;
        bus.hash_signature = 32'd70;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        clear_rec();
        send(32'd70, 1'b0);
        send(32'd80, 1'b0);
        send(32'd90, 1'b0);
        send(32'd65, 1'b0);
        bus.hash_valid = 1'b0;
        wait_done();
        @(posedge clk); #1;
        chk("abort_clr_cycles", clr_cycles, 1);
        check_rec_idx("abort");
        check_sorted("abort", 3, 0, 1, 2);
        chk("abort_done_cnt", done_cnt, 1);
`endif

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
